// File: rtl/flit_pattern_checker.sv
// Receive-side checker for the 46-bit walking-ramp flit stream: counts pattern
// mismatches and bit toggles per packet and reports them with a one-cycle done pulse.
module flit_pattern_checker #(
    parameter int N       = 23,
    parameter int PAYLOAD = 20,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [N-1:0]     input1,
    input  logic [N-1:0]     input2,
    output logic             busy,
    output logic             pkt_done,
    output logic [7:0]       flit_count,
    output logic [CNT_W-1:0] toggle_count,
    output logic [CNT_W-1:0] err_count,
    output logic             trunc_err,
    output logic [CNT_W-1:0] pkt_count
);
    localparam int W  = 2 * N;
    localparam int PW = $clog2(W + 1);

    typedef enum logic {IDLE, RX} state_t;

    function automatic logic [W-1:0] expected_word(input logic [7:0] k);
        logic [W-1:0] ones;
        ones          = '1;
        expected_word = '0;
        if (k >= 8'd1 && k <= 8'd11)
            expected_word = ~(ones >> (4 * int'(k)));
        else if (k >= 8'd12 && k <= 8'd22)
            expected_word = ones >> (4 * int'(k) - W);
    endfunction

    function automatic logic [PW-1:0] popcount(input logic [W-1:0] v);
        popcount = '0;
        for (int i = 0; i < W; i++)
            popcount = popcount + PW'(v[i]);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] tog_q, tog_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [W-1:0]     prev_q, prev_d;
    logic             pkt_done_q, pkt_done_d;
    logic [7:0]       flit_count_q, flit_count_d;
    logic [CNT_W-1:0] toggle_count_q, toggle_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             trunc_err_q, trunc_err_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;

    logic [W-1:0]     word;
    logic [7:0]       idx;
    logic [CNT_W-1:0] tog_next;
    logic [CNT_W-1:0] err_next;

    assign word     = {input2, input1};
    assign idx      = cnt_q + 8'd1;
    assign tog_next = tog_q + CNT_W'(popcount(word ^ prev_q));
    assign err_next = (word != expected_word(idx)) ? sat_inc(err_q) : err_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tog_d          = tog_q;
        err_d          = err_q;
        prev_d         = prev_q;
        pkt_done_d     = 1'b0;
        flit_count_d   = flit_count_q;
        toggle_count_d = toggle_count_q;
        err_count_d    = err_count_q;
        trunc_err_d    = trunc_err_q;
        pkt_count_d    = pkt_count_q;

        if (valid_in) begin
            state_d = RX;
            cnt_d   = idx;
            tog_d   = tog_next;
            err_d   = err_next;
            prev_d  = word;
            // Full close stays in RX so a back-to-back flit starts the next packet seamlessly.
            if (idx == 8'(PAYLOAD)) begin
                pkt_done_d     = 1'b1;
                flit_count_d   = idx;
                toggle_count_d = tog_next;
                err_count_d    = err_next;
                trunc_err_d    = 1'b0;
                pkt_count_d    = pkt_count_q + CNT_W'(1);
                cnt_d          = '0;
                tog_d          = '0;
                err_d          = '0;
                prev_d         = '0;
            end
        end else if (state_q == RX) begin
            state_d = IDLE;
            cnt_d   = '0;
            tog_d   = '0;
            err_d   = '0;
            prev_d  = '0;
            if (cnt_q != 8'd0) begin
                pkt_done_d     = 1'b1;
                flit_count_d   = cnt_q;
                toggle_count_d = tog_q;
                err_count_d    = err_q;
                trunc_err_d    = 1'b1;
                pkt_count_d    = pkt_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            tog_q          <= '0;
            err_q          <= '0;
            prev_q         <= '0;
            pkt_done_q     <= 1'b0;
            flit_count_q   <= '0;
            toggle_count_q <= '0;
            err_count_q    <= '0;
            trunc_err_q    <= 1'b0;
            pkt_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tog_q          <= tog_d;
            err_q          <= err_d;
            prev_q         <= prev_d;
            pkt_done_q     <= pkt_done_d;
            flit_count_q   <= flit_count_d;
            toggle_count_q <= toggle_count_d;
            err_count_q    <= err_count_d;
            trunc_err_q    <= trunc_err_d;
            pkt_count_q    <= pkt_count_d;
        end
    end

    // RX with no flits taken is the slot right after a full close; it only counts as busy if a flit arrives.
    assign busy         = (state_q == RX) && (cnt_q != 8'd0 || valid_in);
    assign pkt_done     = pkt_done_q;
    assign flit_count   = flit_count_q;
    assign toggle_count = toggle_count_q;
    assign err_count    = err_count_q;
    assign trunc_err    = trunc_err_q;
    assign pkt_count    = pkt_count_q;

endmodule
